// File: rtl/adc_xy_fb_mapper_pkg.sv
// Shared constants for the ADC-to-framebuffer coordinate mapper:
// default framebuffer geometry, derived coordinate widths and default colour.
package adc_xy_fb_mapper_pkg;

  localparam int DEF_FB_WIDTH   = 640;
  localparam int DEF_FB_HEIGHT  = 480;
  localparam int DEF_PIXEL_BITS = 12;

  localparam int FB_X_BITS = $clog2(DEF_FB_WIDTH);
  localparam int FB_Y_BITS = $clog2(DEF_FB_HEIGHT);

  localparam logic [DEF_PIXEL_BITS-1:0] DEF_PIXEL_COLOR = {DEF_PIXEL_BITS{1'b1}};

endpackage

// File: rtl/adc_xy_fb_mapper_fifo2.sv
// Two-entry synchronous FIFO. Entry 0 is always the head, so the head data
// only changes on a pop or when an empty FIFO is written.
module adc_xy_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             push_ok,
  input  logic             pop,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  logic [1:0]       count;
  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;
  logic             do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | do_pop);
  assign head    = ent0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push_ok) begin
            ent0  <= din;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (do_pop && push_ok) begin
            ent0 <= din;
          end else if (do_pop) begin
            count <= 2'd0;
          end else if (push_ok) begin
            ent1  <= din;
            count <= 2'd2;
          end
        end
        default: begin
          if (do_pop) begin
            ent0 <= ent1;
            if (push_ok) ent1 <= din;
            else         count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/adc_xy_fb_mapper.sv
// Maps free-running ADC sample pairs onto framebuffer coordinates with exact
// linear scaling, suppresses repeated points and buffers them on a stream.
module adc_xy_fb_mapper
  import adc_xy_fb_mapper_pkg::*;
#(
  parameter int                    ADC_DATA_BITS = 10,
  parameter int                    FB_WIDTH      = DEF_FB_WIDTH,
  parameter int                    FB_HEIGHT     = DEF_FB_HEIGHT,
  parameter int                    PIXEL_BITS    = DEF_PIXEL_BITS,
  parameter logic [PIXEL_BITS-1:0] PIXEL_COLOR   = {PIXEL_BITS{1'b1}},
  parameter bit                    DEDUP         = 1'b1,
  parameter int                    DROP_BITS     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADC_DATA_BITS-1:0]     adc_x,
  input  logic [ADC_DATA_BITS-1:0]     adc_y,
  input  logic                         adc_valid,
  input  logic                         enable,
  output logic [$clog2(FB_WIDTH)-1:0]  out_x,
  output logic [$clog2(FB_HEIGHT)-1:0] out_y,
  output logic [PIXEL_BITS-1:0]        out_color,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DROP_BITS-1:0]         drop_cnt
);

  localparam int X_W  = $clog2(FB_WIDTH);
  localparam int Y_W  = $clog2(FB_HEIGHT);
  localparam int PX_W = ADC_DATA_BITS + X_W + 1;
  localparam int PY_W = ADC_DATA_BITS + Y_W + 1;

  function automatic logic [X_W-1:0] scale_x(input logic [ADC_DATA_BITS-1:0] s);
    logic [PX_W-1:0] prod;
    prod = PX_W'(s) * PX_W'(FB_WIDTH);
    return X_W'(prod >> ADC_DATA_BITS);
  endfunction

  function automatic logic [Y_W-1:0] scale_y(input logic [ADC_DATA_BITS-1:0] s);
    logic [PY_W-1:0] prod;
    prod = PY_W'(s) * PY_W'(FB_HEIGHT);
    return Y_W'(prod >> ADC_DATA_BITS);
  endfunction

  function automatic logic [DROP_BITS-1:0] sat_inc(input logic [DROP_BITS-1:0] c);
    return (&c) ? c : c + DROP_BITS'(1);
  endfunction

  logic [ADC_DATA_BITS-1:0] x_p1, y_p1;
  logic                     vld_p1;
  logic [X_W-1:0]           x_p2, last_x;
  logic [Y_W-1:0]           y_p2, last_y;
  logic                     vld_p2, have_last;
  logic                     dup, push_req, push_ok, pop, drop;
  logic                     fifo_empty, fifo_full;

  // ---- stage p1: capture ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      x_p1   <= '0;
      y_p1   <= '0;
    end else begin
      vld_p1 <= adc_valid & enable;
      if (adc_valid && enable) begin
        x_p1 <= adc_x;
        y_p1 <= adc_y;
      end
    end
  end

  // ---- stage p2: scale ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p2 <= 1'b0;
      x_p2   <= '0;
      y_p2   <= '0;
    end else begin
      vld_p2 <= vld_p1;
      x_p2   <= scale_x(x_p1);
      y_p2   <= scale_y(y_p1);
    end
  end

  // ---- stage p3: dedup and push ----
  assign dup      = DEDUP && have_last && (x_p2 == last_x) && (y_p2 == last_y);
  assign push_req = vld_p2 & ~dup;
  assign pop      = out_ready & ~fifo_empty;
  assign drop     = push_req & fifo_full & ~pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      have_last <= 1'b0;
      last_x    <= '0;
      last_y    <= '0;
      drop_cnt  <= '0;
    end else begin
      if (push_ok) begin
        have_last <= 1'b1;
        last_x    <= x_p2;
        last_y    <= y_p2;
      end
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  adc_xy_fifo2 #(
    .WIDTH (X_W + Y_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push    (push_req),
    .din     ({x_p2, y_p2}),
    .push_ok (push_ok),
    .pop     (pop),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .head    ({out_x, out_y})
  );

  assign out_valid = ~fifo_empty;
  assign out_color = PIXEL_COLOR;

endmodule
